ch_xbuf: RTL and testbench
==========================

# ch_xbuf

Parametrised two-direction channel buffer for one SSDMA engine channel, successor to the fixed 64-bit/512-deep channel buffer. Holds a source FIFO (bus → engine) and a destination FIFO (engine → bus), each carrying a last-tag. It drives the bus-side start/stop/end flow control. Additions over the previous generation:

- parametrised width, depth and thresholds;
- a descriptor word counter that drives the source-side end (`ss_end0`);
- a latched end-of-operation request on the destination side;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- `DW`, 64, data width per word (32 or 64).
- `AW`, 9, log2 FIFO depth; `DEPTH` = 2**`AW`.
- `START_LVL`, 2**(`AW`-1), start threshold in words.
- `STOP_MARGIN`, 4, free-slot margin for stop/almost-full.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous clear of both FIFOs, counter, end latch and errors.
- `dc_i` in 24: descriptor word count for the source direction.
- `ss_xfer0` in 1: push bus word into the source FIFO.
- `ss_last0` in 1: last-tag accompanying that word.
- `ss_dat0` in `DW`: bus word.
- `ss_stop0` out 1: source FIFO almost full.
- `ss_start0` out 1: source FIFO below start level.
- `ss_end0` out 1: `dc_i` words accepted.
- `m_src_getn` in 1: active-low pop of the source FIFO.
- `m_src` out `DW`: source head word.
- `m_src_last` out 1: source head last-tag.
- `m_src_empty` out 1: source FIFO empty.
- `m_src_almost_empty` out 1: source level ≤ 1.
- `m_src_level` out `AW`+1: source occupancy.
- `m_dst_putn` in 1: active-low push into the destination FIFO.
- `m_dst` in `DW`: engine word.
- `m_dst_last` in 1: last-tag for that word.
- `m_endn` in 1: active-low engine end-of-operation.
- `m_dst_full` out 1: destination FIFO full.
- `m_dst_almost_full` out 1: destination FIFO almost full.
- `ss_xfer1` in 1: pop destination FIFO to bus.
- `ss_dat1` out `DW`: destination head word.
- `ss_end1` out 1: destination head is last.
- `ss_start1` out 1: destination ready for bus read.
- `ss_stop1` out 1: same as `m_dst_almost_full`.
- `err_o` out 4: sticky flags {dst_udf, dst_ovf, src_udf, src_ovf}.

## Operation
Each FIFO:
- Storage is a `DEPTH` × (`DW`+1) array with the last-tag in the MSB. The memory is not reset.
- Write pointer, read pointer and level counter are each `AW`+1 bits wide; the pointers wrap modulo `DEPTH`.
- A push is accepted iff the level is below `DEPTH`. A push while full is dropped, the pointer is unchanged, and the overflow flag sets.
- A pop is accepted iff the level is above 0. A pop while empty is ignored and the underflow flag sets.
- Simultaneous push and pop:
  - when full: both are accepted and the level is unchanged;
  - when empty: only the push is accepted, and underflow sets.

Status decodes:
- full: level == `DEPTH`.
- almost_full: level ≥ `DEPTH`−`STOP_MARGIN`.
- empty: level == 0.
- The head data and tag outputs are forced to 0 while empty.

Flow control:
- `ss_start0` = src_level < `START_LVL`.
- `ss_stop0` = src almost_full.
- `ss_start1` = dst_level ≥ `START_LVL` OR (end_pend AND NOT dst empty).
- `ss_end1` = head tag AND NOT dst empty.

end_pend register:
- Set on any cycle where `m_endn`=0.
- Cleared on the edge where the destination FIFO becomes empty with `m_endn`=1.
- Set wins if both occur in the same cycle.

Descriptor counter:
- 24-bit count of accepted `ss_xfer0` pushes.
- `ss_end0` sets on the edge where count+1 == `dc_i` and holds until `clear_i`.
- When `dc_i`=0, `ss_end0` never asserts.
- Further pushes after the count is reached are still stored; the counter saturates at `dc_i`.

`clear_i` has priority over same-cycle push and pop.

## Timing
- Reset (async assert) and `clear_i` (next edge) produce:
  - levels 0;
  - `m_src_empty`=1, `m_src_almost_empty`=1, `ss_start0`=1;
  - every other output 0, including data.
- Write-to-read latency: a word pushed at edge N is visible on the head outputs after edge N, with empty deasserted after the same edge.
- A pop at edge N presents the next word after edge N.
- All status outputs are decoded combinationally from registered levels, so none depends combinationally on the push/pop inputs.
- `err_o` bits set on the edge of the offending cycle and persist until reset or `clear_i`.

## Structure
- Shared package `ssdma_pkg` holds:
  - the `ERR_SRC_OVF`/`ERR_SRC_UDF`/`ERR_DST_OVF`/`ERR_DST_UDF` bit indices;
  - the default `DW`/`AW` constants.
- One sub-module, `ch_fifo` (params `DW`, `AW`, `STOP_MARGIN`), containing:
  - the memory, pointers and level counter;
  - the full/almost_full/empty/almost_empty decodes;
  - ovf/udf pulses and head outputs.
- It is instantiated twice. The top level holds the descriptor counter, end_pend and error latches.

## Test plan
- Reset, then push 3 words 0xA1..0xA3 with last on 0xA3, then pop 3: `m_src` yields A1, A2, A3 with `m_src_last` only on A3, and `m_src_empty` returns to 1.
- Fill the source FIFO with `AW`=4: `ss_stop0` rises at level 12, `m_src_full` internal at 16, and the 17th push sets `err_o`[0] while the stored data is unchanged.
- Push and pop simultaneously while full: level stays at 16 and no error. Pop while empty: `err_o`[1]=1.
- `dc_i`=5, five `ss_xfer0` pushes: `ss_end0` rises after the fifth edge and holds. `clear_i` drops it to 0.
- Destination holds 2 words (< `START_LVL`) and `m_endn` pulses for 1 cycle: `ss_start1`=1 until both words are popped, then 0. `ss_end1`=1 when the tagged word is at the head.
- Assert reset mid-fill: all levels 0, `err_o`=0, `ss_start0`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ssdma_pkg.sv
// ssdma_pkg: constants shared by the SSDMA channel buffer blocks.
//   ERR_* : bit positions inside the 4-bit sticky error vector err_o.
//   DEF_* : default data width / log2 depth of a channel buffer.
package ssdma_pkg;
  localparam int ERR_W       = 4;
  localparam int ERR_SRC_OVF = 0;
  localparam int ERR_SRC_UDF = 1;
  localparam int ERR_DST_OVF = 2;
  localparam int ERR_DST_UDF = 3;

  localparam int DEF_DW = 64;
  localparam int DEF_AW = 9;
  localparam int DC_W   = 24;
endpackage

// File: rtl/ch_fifo.sv
// ch_fifo: one direction of the channel buffer. DEPTH x (DW+1) storage with the
// last-tag in the MSB, wrap-around pointers and an explicit level counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush, wins over push/pop
//   push/push_data/push_last   write request with payload and tag
//   pop               read request (advances the head)
//   head_data/head_last        current head, forced to 0 while empty
//   level             occupancy 0..DEPTH
//   full/almost_full/empty/almost_empty   decodes of the registered level
//   push_acc/pop_acc  request actually taken this cycle
//   ovf/udf           single-cycle pulses for a dropped push / ignored pop
// Handshake: push and pop are request strobes sampled on the clock edge; a
// request is taken (push_acc/pop_acc) when the registered level allows it,
// otherwise it is dropped and reported by ovf/udf. There is no stall.
module ch_fifo #(
  parameter int DW          = 64,
  parameter int AW          = 9,
  parameter int STOP_MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [AW:0]   level,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic          almost_empty,
  output logic          push_acc,
  output logic          pop_acc,
  output logic          ovf,
  output logic          udf
);
  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L     = (AW+1)'(DEPTH - STOP_MARGIN);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_L    = (AW+1)'(1);

  logic [DW:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [DW:0] rd_word;
  logic        ptr_msb_unused;

  function automatic logic [AW:0] next_ptr(input logic [AW:0] p);
    return (p == LAST_IDX) ? '0 : p + ONE_L;
  endfunction

  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign empty        = (level == '0);
  assign almost_empty = (level <= ONE_L);

  // A full FIFO still takes a push when a pop frees the head slot in the same
  // cycle; an empty FIFO never honours a pop, even alongside a push.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign ovf      = push && !push_acc;
  assign udf      = pop && empty;

  // Pointers never leave 0..DEPTH-1, so only the low AW bits address memory.
  assign ptr_msb_unused = wr_ptr[AW] | rd_ptr[AW];

  assign rd_word   = mem[rd_ptr[AW-1:0]];
  assign head_data = empty ? '0 : rd_word[DW-1:0];
  assign head_last = empty ? 1'b0 : rd_word[DW];

  always_ff @(posedge clk) begin
    if (push_acc && !clear) mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) wr_ptr <= next_ptr(wr_ptr);
      if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_acc, pop_acc})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ch_xbuf.sv
// ch_xbuf: two-direction channel buffer for one SSDMA engine channel.
// Source FIFO carries bus words to the engine, destination FIFO carries engine
// words to the bus; both carry a last-tag. Also holds the descriptor word
// counter (ss_end0), the latched engine end request and sticky error flags.
// Ports:
//   wb_clk_i / wb_rst_i   clock / asynchronous active-low reset
//   clear_i               synchronous clear of FIFOs, counter, end latch, errors
//   dc_i                  descriptor word count for the source direction
//   ss_xfer0/ss_last0/ss_dat0      bus push into source FIFO
//   ss_stop0/ss_start0/ss_end0     source-side bus flow control
//   m_src_getn            active-low engine pop of source FIFO
//   m_src*/m_src_level    source head and status
//   m_dst_putn/m_dst/m_dst_last    active-low engine push into destination FIFO
//   m_endn                active-low engine end-of-operation
//   m_dst_full/m_dst_almost_full   destination status to engine
//   ss_xfer1              bus pop of destination FIFO
//   ss_dat1/ss_end1/ss_start1/ss_stop1   destination-side bus outputs
//   err_o                 sticky {dst_udf, dst_ovf, src_udf, src_ovf}
// Handshake: every push/pop input is a one-cycle request strobe; the buffer
// takes it if the registered level allows and otherwise drops it and records
// an error bit. Flow-control outputs are advisory and decoded from registered
// levels only, so no output depends combinationally on a request input.
module ch_xbuf
  import ssdma_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int START_LVL   = 2**(AW-1),
  parameter int STOP_MARGIN = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            clear_i,
  input  logic [DC_W-1:0] dc_i,
  input  logic            ss_xfer0,
  input  logic            ss_last0,
  input  logic [DW-1:0]   ss_dat0,
  output logic            ss_stop0,
  output logic            ss_start0,
  output logic            ss_end0,
  input  logic            m_src_getn,
  output logic [DW-1:0]   m_src,
  output logic            m_src_last,
  output logic            m_src_empty,
  output logic            m_src_almost_empty,
  output logic [AW:0]     m_src_level,
  input  logic            m_dst_putn,
  input  logic [DW-1:0]   m_dst,
  input  logic            m_dst_last,
  input  logic            m_endn,
  output logic            m_dst_full,
  output logic            m_dst_almost_full,
  input  logic            ss_xfer1,
  output logic [DW-1:0]   ss_dat1,
  output logic            ss_end1,
  output logic            ss_start1,
  output logic            ss_stop1,
  output logic [ERR_W-1:0] err_o
);
  localparam logic [AW:0] START_L = (AW+1)'(START_LVL);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic            src_full, src_af, src_push_acc, src_pop_acc, src_ovf, src_udf;
  logic [AW:0]     dst_level;
  logic            dst_empty, dst_ae, dst_last;
  logic            dst_push_acc, dst_pop_acc, dst_ovf, dst_udf;
  logic [DC_W-1:0] dc_cnt;
  logic            end_pend;
  logic            dst_going_empty;
  logic [ERR_W-1:0] err_set;
  logic            status_unused;

  ch_fifo #(.DW(DW), .AW(AW), .STOP_MARGIN(STOP_MARGIN)) u_src (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .clear(clear_i),
    .push(ss_xfer0), .push_data(ss_dat0), .push_last(ss_last0),
    .pop(!m_src_getn),
    .head_data(m_src), .head_last(m_src_last), .level(m_src_level),
    .full(src_full), .almost_full(src_af), .empty(m_src_empty),
    .almost_empty(m_src_almost_empty),
    .push_acc(src_push_acc), .pop_acc(src_pop_acc), .ovf(src_ovf), .udf(src_udf)
  );

  ch_fifo #(.DW(DW), .AW(AW), .STOP_MARGIN(STOP_MARGIN)) u_dst (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .clear(clear_i),
    .push(!m_dst_putn), .push_data(m_dst), .push_last(m_dst_last),
    .pop(ss_xfer1),
    .head_data(ss_dat1), .head_last(dst_last), .level(dst_level),
    .full(m_dst_full), .almost_full(m_dst_almost_full), .empty(dst_empty),
    .almost_empty(dst_ae),
    .push_acc(dst_push_acc), .pop_acc(dst_pop_acc), .ovf(dst_ovf), .udf(dst_udf)
  );

  assign status_unused = src_full | src_pop_acc | dst_ae;

  assign ss_start0 = (m_src_level < START_L);
  assign ss_stop0  = src_af;
  assign ss_stop1  = m_dst_almost_full;
  assign ss_end1   = dst_last && !dst_empty;
  // A pending engine end lets the bus drain a short tail below START_LVL.
  assign ss_start1 = (dst_level >= START_L) || (end_pend && !dst_empty);

  assign dst_going_empty = dst_pop_acc && !dst_push_acc && (dst_level == ONE_L);

  always_comb begin
    err_set              = '0;
    err_set[ERR_SRC_OVF] = src_ovf;
    err_set[ERR_SRC_UDF] = src_udf;
    err_set[ERR_DST_OVF] = dst_ovf;
    err_set[ERR_DST_UDF] = dst_udf;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      dc_cnt   <= '0;
      ss_end0  <= 1'b0;
      end_pend <= 1'b0;
      err_o    <= '0;
    end else if (clear_i) begin
      dc_cnt   <= '0;
      ss_end0  <= 1'b0;
      end_pend <= 1'b0;
      err_o    <= '0;
    end else begin
      // Counter stops at dc_i; dc_i == 0 never matches count+1, so no end.
      if (src_push_acc && (dc_i != '0) && (dc_cnt != dc_i)) begin
        dc_cnt <= dc_cnt + 1'b1;
        if (dc_cnt + 1'b1 == dc_i) ss_end0 <= 1'b1;
      end
      if (!m_endn)              end_pend <= 1'b1;
      else if (dst_going_empty) end_pend <= 1'b0;
      err_o <= err_o | err_set;
    end
  end
endmodule

// File: tb/tb_ch_xbuf.sv
module tb_ch_xbuf;
  localparam int DW          = 64;
  localparam int AW          = 4;
  localparam int DEPTH       = 16;
  localparam int START_LVL   = 8;
  localparam int STOP_MARGIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [23:0]   dc_i = '0;
  logic          ss_xfer0 = 1'b0, ss_last0 = 1'b0;
  logic [DW-1:0] ss_dat0 = '0;
  logic          ss_stop0, ss_start0, ss_end0;
  logic          m_src_getn = 1'b1;
  logic [DW-1:0] m_src;
  logic          m_src_last, m_src_empty, m_src_almost_empty;
  logic [AW:0]   m_src_level;
  logic          m_dst_putn = 1'b1, m_dst_last = 1'b0, m_endn = 1'b1;
  logic [DW-1:0] m_dst = '0;
  logic          m_dst_full, m_dst_almost_full;
  logic          ss_xfer1 = 1'b0;
  logic [DW-1:0] ss_dat1;
  logic          ss_end1, ss_start1, ss_stop1;
  logic [3:0]    err_o;

  int checks = 0;
  int errors = 0;
  int src_lvl = 0;
  int dst_lvl = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] dexp_q[$];

  ch_xbuf #(.DW(DW), .AW(AW), .START_LVL(START_LVL), .STOP_MARGIN(STOP_MARGIN)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .clear_i(clear), .dc_i(dc_i),
    .ss_xfer0(ss_xfer0), .ss_last0(ss_last0), .ss_dat0(ss_dat0),
    .ss_stop0(ss_stop0), .ss_start0(ss_start0), .ss_end0(ss_end0),
    .m_src_getn(m_src_getn), .m_src(m_src), .m_src_last(m_src_last),
    .m_src_empty(m_src_empty), .m_src_almost_empty(m_src_almost_empty),
    .m_src_level(m_src_level),
    .m_dst_putn(m_dst_putn), .m_dst(m_dst), .m_dst_last(m_dst_last), .m_endn(m_endn),
    .m_dst_full(m_dst_full), .m_dst_almost_full(m_dst_almost_full),
    .ss_xfer1(ss_xfer1), .ss_dat1(ss_dat1), .ss_end1(ss_end1),
    .ss_start1(ss_start1), .ss_stop1(ss_stop1), .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (all start and end at a negedge) ----------
  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    dexp_q.delete();
    src_lvl = 0;
    dst_lvl = 0;
  endtask

  task automatic src_push(input logic [DW-1:0] d, input logic l);
    ss_xfer0 = 1'b1; ss_dat0 = d; ss_last0 = l;
    if (src_lvl < DEPTH) begin
      exp_q.push_back({l, d});
      src_lvl++;
    end
    @(negedge clk);
    ss_xfer0 = 1'b0; ss_last0 = 1'b0;
  endtask

  task automatic src_pop(input string name);
    logic [DW:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if ({m_src_last, m_src} !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, {m_src_last, m_src}, e);
    end
    m_src_getn = 1'b0;
    if (src_lvl > 0) src_lvl--;
    @(negedge clk);
    m_src_getn = 1'b1;
  endtask

  task automatic src_push_pop(input logic [DW-1:0] d);
    logic [DW:0] e;
    e = exp_q.pop_front();
    checks++;
    if ({m_src_last, m_src} !== e) begin
      errors++;
      $display("FAIL push_pop_head: got %h expected %h", {m_src_last, m_src}, e);
    end
    exp_q.push_back({1'b0, d});
    ss_xfer0 = 1'b1; ss_dat0 = d; m_src_getn = 1'b0;
    @(negedge clk);
    ss_xfer0 = 1'b0; m_src_getn = 1'b1;
  endtask

  task automatic dst_push(input logic [DW-1:0] d, input logic l);
    m_dst_putn = 1'b0; m_dst = d; m_dst_last = l;
    if (dst_lvl < DEPTH) begin
      dexp_q.push_back({l, d});
      dst_lvl++;
    end
    @(negedge clk);
    m_dst_putn = 1'b1; m_dst_last = 1'b0;
  endtask

  task automatic dst_pop(input string name);
    logic [DW:0] e;
    e = (dexp_q.size() > 0) ? dexp_q.pop_front() : '0;
    checks++;
    if ({ss_end1, ss_dat1} !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, {ss_end1, ss_dat1}, e);
    end
    ss_xfer1 = 1'b1;
    if (dst_lvl > 0) dst_lvl--;
    @(negedge clk);
    ss_xfer1 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_src_empty, m_src_almost_empty, ss_start0} !== 3'b111) begin
      errors++;
      $display("FAIL reset_src_flags: got %b expected 111", {m_src_empty, m_src_almost_empty, ss_start0});
    end
    checks++;
    if ({ss_stop0, ss_end0, m_src_last, m_dst_full, m_dst_almost_full, ss_end1, ss_start1, ss_stop1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_other_flags: got %b expected 00000000",
               {ss_stop0, ss_end0, m_src_last, m_dst_full, m_dst_almost_full, ss_end1, ss_start1, ss_stop1});
    end
    checks++;
    if ({m_src, ss_dat1, m_src_level, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got src=%h dst=%h lvl=%0d err=%b expected all 0", m_src, ss_dat1, m_src_level, err_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    src_push(64'hA1, 1'b0);
    src_push(64'hA2, 1'b0);
    src_push(64'hA3, 1'b1);
    checks++;
    if (m_src_level !== 5'd3 || m_src_empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_level: got lvl=%0d empty=%b expected lvl=3 empty=0", m_src_level, m_src_empty);
    end
    src_pop("basic_pop_a1");
    src_pop("basic_pop_a2");
    checks++;
    if (m_src_almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_almost_empty: got %b expected 1", m_src_almost_empty);
    end
    src_pop("basic_pop_a3");
    checks++;
    if (m_src_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_empty: got %b expected 1", m_src_empty);
    end
  endtask

  task automatic test_fill();
    logic exp_stop, exp_start;
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      src_push(64'(($urandom_range(0, 32'hFFFF) << 8) | i), 1'b0);
      exp_stop  = (src_lvl >= DEPTH - STOP_MARGIN);
      exp_start = (src_lvl < START_LVL);
      checks++;
      if (m_src_level !== 5'(src_lvl) || ss_stop0 !== exp_stop || ss_start0 !== exp_start) begin
        errors++;
        $display("FAIL fill_lvl%0d: got lvl=%0d stop=%b start=%b expected lvl=%0d stop=%b start=%b",
                 i + 1, m_src_level, ss_stop0, ss_start0, src_lvl, exp_stop, exp_start);
      end
    end
    src_push(64'hDEAD_BEEF, 1'b1);
    checks++;
    if (m_src_level !== 5'd16 || err_o !== 4'b0001) begin
      errors++;
      $display("FAIL fill_overflow: got lvl=%0d err=%b expected lvl=16 err=0001", m_src_level, err_o);
    end
    src_push_pop(64'h5A5A);
    src_push_pop(64'h6B6B);
    checks++;
    if (m_src_level !== 5'd16 || err_o !== 4'b0001) begin
      errors++;
      $display("FAIL full_push_pop: got lvl=%0d err=%b expected lvl=16 err=0001", m_src_level, err_o);
    end
    while (exp_q.size() > 0) src_pop("fill_drain");
    m_src_getn = 1'b0;
    @(negedge clk);
    m_src_getn = 1'b1;
    checks++;
    if (err_o !== 4'b0011 || m_src_level !== 5'd0) begin
      errors++;
      $display("FAIL underflow: got err=%b lvl=%0d expected err=0011 lvl=0", err_o, m_src_level);
    end
  endtask

  task automatic test_desc_count();
    do_clear();
    dc_i = 24'd5;
    for (int i = 0; i < 5; i++) begin
      src_push(64'(100 + i), 1'b0);
      checks++;
      if (ss_end0 !== (i == 4)) begin
        errors++;
        $display("FAIL desc_end_push%0d: got %b expected %b", i + 1, ss_end0, (i == 4));
      end
    end
    src_push(64'h77, 1'b0);
    checks++;
    if (ss_end0 !== 1'b1 || m_src_level !== 5'd6) begin
      errors++;
      $display("FAIL desc_hold: got end=%b lvl=%0d expected end=1 lvl=6", ss_end0, m_src_level);
    end
    do_clear();
    checks++;
    if (ss_end0 !== 1'b0 || m_src_level !== 5'd0 || m_src_empty !== 1'b1) begin
      errors++;
      $display("FAIL desc_clear: got end=%b lvl=%0d empty=%b expected 0/0/1", ss_end0, m_src_level, m_src_empty);
    end
    dc_i = 24'd0;
    repeat (3) src_push(64'(($urandom_range(1, 255))), 1'b0);
    checks++;
    if (ss_end0 !== 1'b0) begin
      errors++;
      $display("FAIL desc_zero: got %b expected 0", ss_end0);
    end
    while (exp_q.size() > 0) src_pop("desc_drain");
  endtask

  task automatic test_dst_end();
    do_clear();
    dst_push(64'hD1, 1'b0);
    dst_push(64'hD2, 1'b1);
    checks++;
    if (ss_start1 !== 1'b0) begin
      errors++;
      $display("FAIL dst_start_low: got %b expected 0", ss_start1);
    end
    m_endn = 1'b0;
    @(negedge clk);
    m_endn = 1'b1;
    checks++;
    if (ss_start1 !== 1'b1 || ss_end1 !== 1'b0) begin
      errors++;
      $display("FAIL dst_end_pend: got start=%b end=%b expected start=1 end=0", ss_start1, ss_end1);
    end
    dst_pop("dst_pop_d1");
    checks++;
    if (ss_start1 !== 1'b1 || ss_end1 !== 1'b1) begin
      errors++;
      $display("FAIL dst_tail: got start=%b end=%b expected start=1 end=1", ss_start1, ss_end1);
    end
    dst_pop("dst_pop_d2");
    checks++;
    if (ss_start1 !== 1'b0 || ss_end1 !== 1'b0) begin
      errors++;
      $display("FAIL dst_drained: got start=%b end=%b expected 0/0", ss_start1, ss_end1);
    end
    dst_push(64'hD3, 1'b0);
    checks++;
    if (ss_start1 !== 1'b0) begin
      errors++;
      $display("FAIL dst_pend_cleared: got %b expected 0", ss_start1);
    end
    dst_pop("dst_pop_d3");
  endtask

  task automatic test_dst_fill();
    logic exp_af, exp_full, exp_start;
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      dst_push(64'($urandom_range(0, 32'hFFFF_FFFF)), (i == DEPTH - 1));
      exp_af    = (dst_lvl >= DEPTH - STOP_MARGIN);
      exp_full  = (dst_lvl == DEPTH);
      exp_start = (dst_lvl >= START_LVL);
      checks++;
      if (m_dst_almost_full !== exp_af || ss_stop1 !== exp_af || m_dst_full !== exp_full || ss_start1 !== exp_start) begin
        errors++;
        $display("FAIL dst_fill_lvl%0d: got af=%b stop1=%b full=%b start1=%b expected af=%b full=%b start1=%b",
                 i + 1, m_dst_almost_full, ss_stop1, m_dst_full, ss_start1, exp_af, exp_full, exp_start);
      end
    end
    dst_push(64'hBAD, 1'b0);
    checks++;
    if (err_o !== 4'b0100) begin
      errors++;
      $display("FAIL dst_overflow: got %b expected 0100", err_o);
    end
    while (dexp_q.size() > 0) dst_pop("dst_fill_drain");
    ss_xfer1 = 1'b1;
    @(negedge clk);
    ss_xfer1 = 1'b0;
    checks++;
    if (err_o !== 4'b1100) begin
      errors++;
      $display("FAIL dst_underflow: got %b expected 1100", err_o);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    m_src_getn = 1'b0;
    @(negedge clk);
    m_src_getn = 1'b1;
    repeat (3) src_push(64'($urandom_range(1, 1000)), 1'b0);
    checks++;
    if (err_o !== 4'b0010 || m_src_level !== 5'd3) begin
      errors++;
      $display("FAIL pre_reset: got err=%b lvl=%0d expected err=0010 lvl=3", err_o, m_src_level);
    end
    ss_xfer0 = 1'b1; ss_dat0 = 64'hFEED;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_src_level !== 5'd0 || err_o !== 4'b0000 || ss_start0 !== 1'b1 || m_src_empty !== 1'b1 || m_src !== '0) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d err=%b start0=%b empty=%b src=%h expected 0/0000/1/1/0",
               m_src_level, err_o, ss_start0, m_src_empty, m_src);
    end
    ss_xfer0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    src_lvl = 0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_desc_count();
    test_dst_end();
    test_dst_fill();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
